// File: rtl/wb_axi_pkg.sv
// wb_axi_pkg: FSM state encoding and AXI response codes shared by the Wishbone/AXI4-Lite bridges.
package wb_axi_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_RESP,
    TERM
  } state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp == RESP_SLVERR || resp == RESP_DECERR;
  endfunction
endpackage

// File: rtl/wishbone_to_axi4lite.sv
// wishbone_to_axi4lite: Wishbone classic slave to AXI4-Lite master bridge, one transaction in flight.
// Define WB2AXI_ERR_EN to turn SLVERR/DECERR responses into wb_err_o instead of wb_ack_o.
module wishbone_to_axi4lite
  import wb_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      wb_rst_i,
  output logic                      axi_aresetn_o,
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [ADDR_WIDTH-1:0]     axi_awaddr_o,
  output logic                      axi_awvalid_o,
  input  logic                      axi_awready_i,
  output logic [DATA_WIDTH-1:0]     axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb_o,
  output logic                      axi_wvalid_o,
  input  logic                      axi_wready_i,
  input  logic [1:0]                axi_bresp_i,
  input  logic                      axi_bvalid_i,
  output logic                      axi_bready_o,
  output logic [ADDR_WIDTH-1:0]     axi_araddr_o,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  input  logic [DATA_WIDTH-1:0]     axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o,
  output logic [2:0]                axi_awprot_o,
  output logic [2:0]                axi_arprot_o
);
  state_t state, state_nx;
  logic aw_done, w_done, req, aw_fire, w_fire, term_pulse;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  assign req = wb_cyc_i & wb_stb_i;
  assign aw_fire = axi_awvalid_o & axi_awready_i;
  assign w_fire = axi_wvalid_o & axi_wready_i;
  assign axi_aresetn_o = ~wb_rst_i;
  assign wb_rty_o = 1'b0;
  assign axi_awprot_o = 3'b000;
  assign axi_arprot_o = 3'b000;
  assign axi_awaddr_o = adr_q;
  assign axi_araddr_o = adr_q;
  assign axi_wdata_o = dat_q;
  assign axi_wstrb_o = sel_q;
  always_ff @(posedge clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         state_nx = req ? (wb_we_i ? WR_ADDR_DATA : RD_ADDR) : IDLE;
      WR_ADDR_DATA: state_nx = ((aw_done | aw_fire) & (w_done | w_fire)) ? WR_RESP : WR_ADDR_DATA;
      WR_RESP:      state_nx = axi_bvalid_i ? TERM : WR_RESP;
      RD_ADDR:      state_nx = axi_arready_i ? RD_RESP : RD_ADDR;
      RD_RESP:      state_nx = axi_rvalid_i ? TERM : RD_RESP;
      TERM:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end
  // Valids/readies decode straight from registered state, so they drop the cycle after their handshake.
  always_comb begin
    axi_awvalid_o = state == WR_ADDR_DATA && !aw_done;
    axi_wvalid_o  = state == WR_ADDR_DATA && !w_done;
    axi_bready_o  = state == WR_RESP;
    axi_arvalid_o = state == RD_ADDR;
    axi_rready_o  = state == RD_RESP;
    term_pulse    = state == TERM && wb_cyc_i;
  end
  always_ff @(posedge clk_i) begin
    if (wb_rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      if (state == IDLE && req) begin
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
      end
      aw_done <= state == WR_ADDR_DATA && (aw_done | aw_fire);
      w_done <= state == WR_ADDR_DATA && (w_done | w_fire);
      if (state == RD_RESP && axi_rvalid_i) wb_dat_o <= axi_rdata_i;
    end
  end
`ifdef WB2AXI_ERR_EN
  logic resp_err;
  always_ff @(posedge clk_i) begin
    if (wb_rst_i) resp_err <= 1'b0;
    else if (state == WR_RESP && axi_bvalid_i) resp_err <= resp_is_err(axi_bresp_i);
    else if (state == RD_RESP && axi_rvalid_i) resp_err <= resp_is_err(axi_rresp_i);
  end
  assign wb_ack_o = term_pulse & ~resp_err;
  assign wb_err_o = term_pulse & resp_err;
`else
  logic unused_resp;
  assign unused_resp = ^{axi_bresp_i, axi_rresp_i};
  assign wb_ack_o = term_pulse;
  assign wb_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// tb_wishbone_to_axi4lite: randomized Wishbone master and AXI4-Lite slave around the bridge, checked against a memory model.
module tb_wishbone_to_axi4lite;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef WB2AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic wb_rst_i;
  logic axi_aresetn_o;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i, wb_dat_o;
  logic [SW-1:0] wb_sel_i;
  logic wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o, wb_rty_o;
  logic [AW-1:0] axi_awaddr_o, axi_araddr_o;
  logic axi_awvalid_o, axi_awready_i, axi_wvalid_o, axi_wready_i;
  logic [DW-1:0] axi_wdata_o, axi_rdata_i;
  logic [SW-1:0] axi_wstrb_o;
  logic [1:0] axi_bresp_i, axi_rresp_i;
  logic axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i, axi_rvalid_i, axi_rready_o;
  logic [2:0] axi_awprot_o, axi_arprot_o;

  always #5 clk_i = ~clk_i;

  wishbone_to_axi4lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .wb_rst_i(wb_rst_i), .axi_aresetn_o(axi_aresetn_o),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_awprot_o(axi_awprot_o), .axi_arprot_o(axi_arprot_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction
  function automatic logic [DW-1:0] def_word(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction
  function automatic logic exp_err(input logic [1:0] r);
    return r[1] & ERR_EN;
  endfunction

  // AXI4-Lite slave: programmable ready/response delays, its own register file.
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic aw_got, w_got, ar_got, aw_hs, w_hs, ar_hs;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  bit [DW-1:0] smem [256];
  bit smem_v [256];
  function automatic logic [DW-1:0] sread(input logic [AW-1:0] a);
    return smem_v[idx(a)] ? smem[idx(a)] : def_word(a);
  endfunction
  assign axi_awready_i = axi_awvalid_o && aw_cnt >= aw_wait;
  assign axi_wready_i = axi_wvalid_o && w_cnt >= w_wait;
  assign axi_arready_i = axi_arvalid_o && ar_cnt >= ar_wait;
  assign aw_hs = axi_awvalid_o & axi_awready_i;
  assign w_hs = axi_wvalid_o & axi_wready_i;
  assign ar_hs = axi_arvalid_o & axi_arready_i;
  always @(posedge clk_i) begin
    if (!axi_aresetn_o) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      axi_bvalid_i <= 1'b0; axi_rvalid_i <= 1'b0;
      axi_bresp_i <= 2'b00; axi_rresp_i <= 2'b00; axi_rdata_i <= '0;
    end else begin
      aw_cnt <= (axi_awvalid_o && !axi_awready_i) ? aw_cnt + 1 : 0;
      w_cnt <= (axi_wvalid_o && !axi_wready_i) ? w_cnt + 1 : 0;
      ar_cnt <= (axi_arvalid_o && !axi_arready_i) ? ar_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= axi_awaddr_o; n_aw <= n_aw + 1; end
      if (w_hs) begin w_got <= 1'b1; s_wdata <= axi_wdata_o; s_wstrb <= axi_wstrb_o; n_w <= n_w + 1; end
      if (ar_hs) begin ar_got <= 1'b1; s_araddr <= axi_araddr_o; n_ar <= n_ar + 1; end
      if (axi_bvalid_i) begin
        if (axi_bready_o) begin
          axi_bvalid_i <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; n_b <= n_b + 1;
          smem[idx(s_awaddr)] <= merge(sread(s_awaddr), s_wdata, s_wstrb);
          smem_v[idx(s_awaddr)] <= 1'b1;
        end
      end else if ((aw_got | aw_hs) && (w_got | w_hs)) begin
        if (b_cnt >= b_wait) begin axi_bvalid_i <= 1'b1; axi_bresp_i <= b_resp_cfg; end
        else b_cnt <= b_cnt + 1;
      end
      if (axi_rvalid_i) begin
        if (axi_rready_o) begin axi_rvalid_i <= 1'b0; ar_got <= 1'b0; r_cnt <= 0; n_r <= n_r + 1; end
      end else if (ar_got | ar_hs) begin
        if (r_cnt >= r_wait) begin
          axi_rvalid_i <= 1'b1; axi_rresp_i <= r_resp_cfg;
          axi_rdata_i <= sread(ar_hs ? axi_araddr_o : s_araddr);
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Every-cycle rule checks: tie-offs, termination exclusivity, AXI hold rules, read-data hold, reset clearing.
  logic p_ok = 1'b0;
  logic p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rhs;
  logic [AW-1:0] p_awa, p_ara;
  logic [DW-1:0] p_wd, p_rd, p_dat;
  logic [SW-1:0] p_ws;
  always @(negedge clk_i) begin
    chk("rty_tied", wb_rty_o, 0);
    chk("prot_tied", {axi_awprot_o, axi_arprot_o}, 0);
    chk("aresetn", axi_aresetn_o, !wb_rst_i);
    chk("ack_err_exclusive", wb_ack_o & wb_err_o, 0);
    chk("term_without_cyc", (wb_ack_o | wb_err_o) & !wb_cyc_i, 0);
    if (axi_bready_o) chk("bready_after_aw_w", {axi_awvalid_o, axi_wvalid_o}, 0);
    if (p_ok && p_rst)
      chk("reset_clears", {axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o, wb_ack_o, wb_err_o, wb_dat_o}, 0);
    if (p_ok && !p_rst) begin
      if (p_awv && !p_awr) chk("aw_hold", {axi_awvalid_o, axi_awaddr_o}, {1'b1, p_awa});
      if (p_wv && !p_wr) chk("w_hold", {axi_wvalid_o, axi_wstrb_o, axi_wdata_o}, {1'b1, p_ws, p_wd});
      if (p_arv && !p_arr) chk("ar_hold", {axi_arvalid_o, axi_araddr_o}, {1'b1, p_ara});
      chk("dat_o_hold", wb_dat_o, p_rhs ? p_rd : p_dat);
    end
    p_ok <= 1'b1;
    p_rst <= wb_rst_i;
    p_awv <= axi_awvalid_o; p_awr <= axi_awready_i; p_awa <= axi_awaddr_o;
    p_wv <= axi_wvalid_o; p_wr <= axi_wready_i; p_wd <= axi_wdata_o; p_ws <= axi_wstrb_o;
    p_arv <= axi_arvalid_o; p_arr <= axi_arready_i; p_ara <= axi_araddr_o;
    p_rhs <= axi_rvalid_i & axi_rready_o; p_rd <= axi_rdata_i; p_dat <= wb_dat_o;
  end

  // Master-side model of what the peripheral space should hold.
  bit [DW-1:0] mmem [256];
  bit mmem_v [256];
  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return mmem_v[idx(a)] ? mmem[idx(a)] : def_word(a);
  endfunction

  // Called just after a rising edge; returns just after a rising edge with the bus idle.
  task automatic wb_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        output int lat, output logic ga, output logic ge, output logic [DW-1:0] rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    lat = -1; ga = 1'b0; ge = 1'b0; rd = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (n == 0) chk("no_term_in_request_cycle", {wb_ack_o, wb_err_o}, 0);
      if (wb_ack_o | wb_err_o) begin
        ga = wb_ack_o; ge = wb_err_o; rd = wb_dat_o; lat = n;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (lat < 0) chk("txn_timeout", 1, 0);
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, input int exp_lat);
    int lat, aw0, w0, b0, ar0;
    logic ga, ge;
    logic [DW-1:0] rd;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar;
    wb_txn(1'b1, a, d, s, lat, ga, ge, rd);
    chk("wr_ack", ga, !exp_err(b_resp_cfg));
    chk("wr_err", ge, exp_err(b_resp_cfg));
    chk("wr_handshake_counts", {n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0}, {32'd1, 32'd1, 32'd1, 32'd0});
    chk("wr_awaddr", s_awaddr, a);
    chk("wr_wdata_wstrb", {s_wstrb, s_wdata}, {s, d});
    if (exp_lat >= 0) chk("wr_latency", lat, exp_lat);
    mmem[idx(a)] = merge(mrd(a), d, s);
    mmem_v[idx(a)] = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int exp_lat, output logic [DW-1:0] rd);
    int lat, aw0, ar0, r0;
    logic ga, ge;
    aw0 = n_aw; ar0 = n_ar; r0 = n_r;
    wb_txn(1'b0, a, $urandom, '0, lat, ga, ge, rd);
    chk("rd_ack", ga, !exp_err(r_resp_cfg));
    chk("rd_err", ge, exp_err(r_resp_cfg));
    chk("rd_data", rd, mrd(a));
    chk("rd_handshake_counts", {n_ar - ar0, n_r - r0, n_aw - aw0}, {32'd1, 32'd1, 32'd0});
    chk("rd_araddr", s_araddr, a);
    if (exp_lat >= 0) chk("rd_latency", lat, exp_lat);
  endtask

  task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic seen;
    int r0, aw0;
    logic [AW-1:0] a;
    wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_state", {axi_aresetn_o, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, wb_ack_o, wb_dat_o}, 0);
    @(posedge clk_i); #1;
    wb_rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Zero-wait write: request cycle, AW+W, B, then ack in the fourth cycle.
    do_write(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 3);
    chk("pin_write_awaddr_wdata", {s_awaddr, s_wdata}, 64'h1000_0010_DEAD_BEEF);

    // Skewed write: wready three cycles after awready.
    set_waits(0, 3, 0, 0, 0);
    do_write(32'h2000_0004, 32'hCAFE_F00D, 4'hF, 6);

    // Read with rvalid two cycles after rready.
    set_waits(0, 0, 0, 0, 2);
    do_read(32'h2000_0004, 5, rd);
    chk("pin_read_data", rd, 32'hCAFE_F00D);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("pin_read_data_stable", wb_dat_o, 32'hCAFE_F00D);
    @(posedge clk_i); #1;

    // Error responses.
    set_waits(0, 0, 0, 0, 0);
    b_resp_cfg = 2'b10;
    do_write(32'h1000_0010, 32'h1234_5678, 4'h3, 3);
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11;
    do_read(32'h1000_0010, 3, rd);
    chk("pin_errored_read_data", rd, 32'hDEAD_5678);
    r_resp_cfg = 2'b00;

    // Master abort while waiting for R: handshake still completes, no termination.
    set_waits(0, 0, 0, 0, 4);
    a = 32'h2000_0004;
    r0 = n_r;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    repeat (2) begin @(posedge clk_i); #1; end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      seen = seen | wb_ack_o | wb_err_o;
    end
    chk("abort_no_term", seen, 0);
    chk("abort_r_completed", n_r - r0, 1);
    chk("abort_data_latched", wb_dat_o, mrd(a));
    @(posedge clk_i); #1;
    set_waits(0, 0, 0, 0, 0);
    do_write(32'h3000_0100, 32'h0BAD_F00D, 4'hF, 3);
    do_read(32'h3000_0100, 3, rd);

    // Reset in the middle of a write.
    set_waits(4, 4, 0, 0, 0);
    aw0 = n_aw;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h3000_0100; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pre_reset_valids", {axi_awvalid_o, axi_wvalid_o}, 2'b11);
    @(posedge clk_i); #1;
    wb_rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_reset_aresetn", axi_aresetn_o, 0);
    @(posedge clk_i); #1;
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_idle", {axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o, wb_ack_o, wb_err_o}, 0);
    chk("post_reset_no_aw", n_aw - aw0, 0);
    @(posedge clk_i); #1;
    set_waits(0, 0, 0, 0, 0);
    do_read(32'h3000_0100, 3, rd);
    chk("pin_reset_dropped_write", rd, 32'h0BAD_F00D);

    // Randomized traffic, including back-to-back requests.
    for (int t = 0; t < 80; t++) begin
      set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      b_resp_cfg = 2'($urandom_range(0, 3));
      r_resp_cfg = 2'($urandom_range(0, 3));
      a = 32'h3000_0100 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), -1);
      else do_read(a, -1, rd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
